// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
// Shared ISA definitions for the 8-bit CPU control path.
//   - opcode constants OP_NOP .. OP_HLT
//   - ALU operation encodings ALU_PASS / ALU_ADD / ALU_SUB
//   - ctrl_word_t: packed control word produced by the opcode decoder
//   - CTRL_NOP: the all-inactive control word
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       acc_load;
        logic       mem_read;
        logic       mem_write;
        logic       imm_select;
        logic       halt;
        logic       jump;
        logic       jz;
        logic       illegal;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = ctrl_word_t'(10'b0);

endpackage

// File: rtl/control_decoder_opcode_decode.sv
// -----------------------------------------------------------------------------
// opcode_decode
// Purely combinational opcode -> control word mapping.
// Ports:
//   opcode : input  [OPCODE_WIDTH-1:0]  upper instruction bits
//   ctrl   : output ctrl_word_t         decoded control word; unknown opcodes
//                                       return an otherwise-empty word with
//                                       the illegal bit set
// Configuration macro: CONTROL_DECODER_BRANCH_EN
//   defined   -> 0x6 JMP and 0x7 JZ decode to branch control words
//   undefined -> 0x6 and 0x7 are illegal
// -----------------------------------------------------------------------------
module opcode_decode
    import cpu_isa_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output ctrl_word_t              ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_NOP: ;
            OP_LDA: begin
                ctrl.mem_read = 1'b1;
                ctrl.acc_load = 1'b1;
                ctrl.alu_op   = ALU_PASS;
            end
            OP_ADD: begin
                ctrl.mem_read = 1'b1;
                ctrl.acc_load = 1'b1;
                ctrl.alu_op   = ALU_ADD;
            end
            OP_SUB: begin
                ctrl.mem_read = 1'b1;
                ctrl.acc_load = 1'b1;
                ctrl.alu_op   = ALU_SUB;
            end
            OP_STA: ctrl.mem_write = 1'b1;
            OP_LDI: begin
                ctrl.acc_load   = 1'b1;
                ctrl.imm_select = 1'b1;
            end
            OP_HLT: ctrl.halt = 1'b1;
`ifdef CONTROL_DECODER_BRANCH_EN
            OP_JMP: ctrl.jump = 1'b1;
            OP_JZ:  ctrl.jz   = 1'b1;
`endif
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_decoder.sv
// -----------------------------------------------------------------------------
// control_decoder
// Owns PC, IR and the registered control word of the 8-bit CPU. Consumes the
// one-hot fetch/decode/execute/increment strobes from the sequence generator
// and drives datapath strobes combinationally during execute.
// Ports:
//   clock, input_clear (sync active-high reset), input_clock_enable
//   input_fetch / input_decode / input_execute / input_increment : phase strobes
//   input_instruction : instruction byte,  input_zero_flag : ALU zero flag
//   output_address    : PC, or zero-extended operand in execute of memory ops
//   output_ir / output_operand : IR and its low operand bits
//   output_alu_op, output_acc_load, output_mem_read, output_mem_write,
//   output_imm_select : execute-phase datapath controls
//   output_halt : CPU halted,  output_illegal : illegal opcode / phase error
// Configuration macro: CONTROL_DECODER_BRANCH_EN (enables JMP / JZ)
// -----------------------------------------------------------------------------
module control_decoder
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                                clock,
    input  logic                                input_clear,
    input  logic                                input_clock_enable,
    input  logic                                input_fetch,
    input  logic                                input_decode,
    input  logic                                input_execute,
    input  logic                                input_increment,
    input  logic [DATA_WIDTH-1:0]               input_instruction,
    input  logic                                input_zero_flag,
    output logic [ADDR_WIDTH-1:0]               output_address,
    output logic [DATA_WIDTH-1:0]               output_ir,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0]  output_operand,
    output logic [1:0]                          output_alu_op,
    output logic                                output_acc_load,
    output logic                                output_mem_read,
    output logic                                output_mem_write,
    output logic                                output_imm_select,
    output logic                                output_halt,
    output logic                                output_illegal
);

    localparam int OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;

    logic [ADDR_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    ir;
    ctrl_word_t               ctrl_word;
    ctrl_word_t               dec_word;
    logic                     halted;
    logic                     jump_pending;
    logic                     illegal_pulse;
    logic                     phase_err;
    logic                     active;
    logic                     exec_on;
    logic [OPERAND_WIDTH-1:0] operand;
    logic [ADDR_WIDTH-1:0]    operand_addr;

    assign operand      = ir[OPERAND_WIDTH-1:0];
    assign operand_addr = {{(ADDR_WIDTH-OPERAND_WIDTH){1'b0}}, operand};

    // More than one phase strobe at once is a sequencer fault: nothing moves.
    assign phase_err = ({input_fetch, input_decode, input_execute, input_increment} != 4'b0000) &&
                       !$onehot({input_fetch, input_decode, input_execute, input_increment});
    assign active    = input_clock_enable && !halted && !phase_err;
    assign exec_on   = active && input_execute;

    opcode_decode #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_opcode_decode (
        .opcode (ir[DATA_WIDTH-1 -: OPCODE_WIDTH]),
        .ctrl   (dec_word)
    );

    // ---- state: PC, IR, control word, halt, illegal pulse ----
    always_ff @(posedge clock) begin
        if (input_clear) begin
            pc            <= '0;
            ir            <= '0;
            ctrl_word     <= CTRL_NOP;
            halted        <= 1'b0;
            illegal_pulse <= 1'b0;
        end else begin
            illegal_pulse <= 1'b0;
            if (active) begin
                if (input_fetch) begin
                    ir <= input_instruction;
                end
                if (input_decode) begin
                    ctrl_word     <= dec_word.illegal ? CTRL_NOP : dec_word;
                    illegal_pulse <= dec_word.illegal;
                end
                if (input_execute && ctrl_word.halt) begin
                    halted <= 1'b1;
                end
                if (input_increment) begin
                    if (jump_pending) begin
                        pc <= operand_addr;
                    end else begin
                        pc <= pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

`ifdef CONTROL_DECODER_BRANCH_EN
    // ---- branch state: resolved at execute, consumed at increment ----
    always_ff @(posedge clock) begin
        if (input_clear) begin
            jump_pending <= 1'b0;
        end else if (active) begin
            if (input_execute) begin
                jump_pending <= ctrl_word.jump || (ctrl_word.jz && input_zero_flag);
            end else if (input_increment) begin
                jump_pending <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, ctrl_word.illegal};
`else
    assign jump_pending = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, ctrl_word.illegal, ctrl_word.jump, ctrl_word.jz, input_zero_flag};
`endif

    // ---- outputs ----
    always_comb begin
        output_address    = pc;
        output_alu_op     = ALU_PASS;
        output_acc_load   = 1'b0;
        output_mem_read   = 1'b0;
        output_mem_write  = 1'b0;
        output_imm_select = 1'b0;
        if (exec_on) begin
            output_alu_op     = ctrl_word.alu_op;
            output_acc_load   = ctrl_word.acc_load;
            output_mem_read   = ctrl_word.mem_read;
            output_mem_write  = ctrl_word.mem_write;
            output_imm_select = ctrl_word.imm_select;
            if (ctrl_word.mem_read || ctrl_word.mem_write) begin
                output_address = operand_addr;
            end
        end
    end

    assign output_ir      = ir;
    assign output_operand = operand;
    assign output_halt    = halted;
    assign output_illegal = illegal_pulse || phase_err;

endmodule

// File: tb/tb_control_decoder.sv
module tb_control_decoder;

    logic       clock = 1'b0;
    logic       input_clear;
    logic       input_clock_enable;
    logic       input_fetch;
    logic       input_decode;
    logic       input_execute;
    logic       input_increment;
    logic [7:0] input_instruction;
    logic       input_zero_flag;
    logic [7:0] output_address;
    logic [7:0] output_ir;
    logic [3:0] output_operand;
    logic [1:0] output_alu_op;
    logic       output_acc_load;
    logic       output_mem_read;
    logic       output_mem_write;
    logic       output_imm_select;
    logic       output_halt;
    logic       output_illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    control_decoder dut (
        .clock              (clock),
        .input_clear        (input_clear),
        .input_clock_enable (input_clock_enable),
        .input_fetch        (input_fetch),
        .input_decode       (input_decode),
        .input_execute      (input_execute),
        .input_increment    (input_increment),
        .input_instruction  (input_instruction),
        .input_zero_flag    (input_zero_flag),
        .output_address     (output_address),
        .output_ir          (output_ir),
        .output_operand     (output_operand),
        .output_alu_op      (output_alu_op),
        .output_acc_load    (output_acc_load),
        .output_mem_read    (output_mem_read),
        .output_mem_write   (output_mem_write),
        .output_imm_select  (output_imm_select),
        .output_halt        (output_halt),
        .output_illegal     (output_illegal)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // phase order {fetch, decode, execute, increment}
    task automatic drive(input logic [3:0] ph);
        {input_fetch, input_decode, input_execute, input_increment} = ph;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Fetch and decode an instruction, leaving the execute strobe applied.
    task automatic to_execute(input logic [7:0] instr);
        input_instruction = instr;
        drive(4'b1000); tick;
        drive(4'b0100); tick;
        drive(4'b0010);
    endtask

    // Complete execute and increment, then idle.
    task automatic finish_instr;
        tick;
        drive(4'b0001); tick;
        drive(4'b0000);
    endtask

    initial begin
        input_clear        = 1'b1;
        input_clock_enable = 1'b1;
        input_instruction  = 8'h00;
        input_zero_flag    = 1'b0;
        drive(4'b0000);
        tick; tick;
        input_clear = 1'b0;
        #1;

        // reset state
        check("rst_addr",    32'(output_address), 32'h00);
        check("rst_ir",      32'(output_ir), 32'h00);
        check("rst_halt",    32'(output_halt), 32'h0);
        check("rst_illegal", 32'(output_illegal), 32'h0);
        check("rst_acc",     32'(output_acc_load), 32'h0);

        // LDI 0x53
        input_instruction = 8'h53;
        drive(4'b1000);
        check("ldi_fetch_addr", 32'(output_address), 32'h00);
        tick;
        check("ldi_ir", 32'(output_ir), 32'h53);
        drive(4'b0100); tick;
        drive(4'b0010);
        check("ldi_acc",     32'(output_acc_load), 32'h1);
        check("ldi_imm",     32'(output_imm_select), 32'h1);
        check("ldi_operand", 32'(output_operand), 32'h3);
        check("ldi_memrd",   32'(output_mem_read), 32'h0);
        check("ldi_addr",    32'(output_address), 32'h00);
        finish_instr;
        check("ldi_pc", 32'(output_address), 32'h01);

        // ADD 0x2A
        to_execute(8'h2A);
        check("add_addr",  32'(output_address), 32'h0A);
        check("add_memrd", 32'(output_mem_read), 32'h1);
        check("add_acc",   32'(output_acc_load), 32'h1);
        check("add_alu",   32'(output_alu_op), 32'h1);
        finish_instr;
        check("add_alu_idle", 32'(output_alu_op), 32'h0);
        check("add_pc",       32'(output_address), 32'h02);

        // STA 0x47
        to_execute(8'h47);
        check("sta_memwr", 32'(output_mem_write), 32'h1);
        check("sta_addr",  32'(output_address), 32'h07);
        check("sta_acc",   32'(output_acc_load), 32'h0);
        finish_instr;
        check("sta_pc", 32'(output_address), 32'h03);

        // clock enable low over a full phase set
        input_clock_enable = 1'b0;
        input_instruction  = 8'h99;
        drive(4'b1000); tick;
        drive(4'b0100); tick;
        drive(4'b0010); tick;
        drive(4'b0001); tick;
        drive(4'b0000);
        input_clock_enable = 1'b1;
        #1;
        check("ce_pc", 32'(output_address), 32'h03);
        check("ce_ir", 32'(output_ir), 32'h47);

        // illegal opcode 0x9
        input_instruction = 8'h95;
        drive(4'b1000); tick;
        drive(4'b0100);
        check("ill_before", 32'(output_illegal), 32'h0);
        tick;
        drive(4'b0010);
        check("ill_pulse", 32'(output_illegal), 32'h1);
        check("ill_acc",   32'(output_acc_load), 32'h0);
        check("ill_memrd", 32'(output_mem_read), 32'h0);
        check("ill_memwr", 32'(output_mem_write), 32'h0);
        tick;
        drive(4'b0000);
        check("ill_end", 32'(output_illegal), 32'h0);
        drive(4'b0001); tick;
        drive(4'b0000);
        check("ill_pc", 32'(output_address), 32'h04);

        // phase error: fetch and decode together
        input_instruction = 8'h12;
        drive(4'b1100);
        check("perr_illegal", 32'(output_illegal), 32'h1);
        tick;
        drive(4'b0000);
        check("perr_ir",    32'(output_ir), 32'h95);
        check("perr_pc",    32'(output_address), 32'h04);
        check("perr_clear", 32'(output_illegal), 32'h0);

        // NOP to reach PC=0x05, then HLT
        to_execute(8'h00);
        finish_instr;
        check("nop_pc", 32'(output_address), 32'h05);
        to_execute(8'hF0);
        tick;
        check("hlt_halt", 32'(output_halt), 32'h1);
        drive(4'b0001); tick;
        drive(4'b0000);
        check("hlt_pc", 32'(output_address), 32'h05);
        input_instruction = 8'h53;
        drive(4'b1000); tick;
        drive(4'b0000);
        check("hlt_ir_frozen", 32'(output_ir), 32'hF0);
        input_clear = 1'b1;
        tick;
        input_clear = 1'b0;
        #1;
        check("clr_pc",   32'(output_address), 32'h00);
        check("clr_halt", 32'(output_halt), 32'h0);

        // PC wrap: 255 increments to 0xFF, then one NOP
        for (int k = 0; k < 255; k++) begin
            drive(4'b0001); tick;
        end
        drive(4'b0000);
        check("wrap_ff", 32'(output_address), 32'hFF);
        to_execute(8'h00);
        finish_instr;
        check("wrap_00", 32'(output_address), 32'h00);

        // JMP 0x63
        input_instruction = 8'h63;
        drive(4'b1000); tick;
        drive(4'b0100); tick;
        drive(4'b0010);
`ifdef CONTROL_DECODER_BRANCH_EN
        check("jmp_noill", 32'(output_illegal), 32'h0);
`else
        check("jmp_ill", 32'(output_illegal), 32'h1);
`endif
        check("jmp_acc",   32'(output_acc_load), 32'h0);
        check("jmp_memwr", 32'(output_mem_write), 32'h0);
        finish_instr;
`ifdef CONTROL_DECODER_BRANCH_EN
        check("jmp_pc", 32'(output_address), 32'h03);
`else
        check("jmp_pc", 32'(output_address), 32'h01);
`endif

        // JZ 0x7C taken, then not taken
        input_zero_flag = 1'b1;
        to_execute(8'h7C);
        finish_instr;
`ifdef CONTROL_DECODER_BRANCH_EN
        check("jz_taken_pc", 32'(output_address), 32'h0C);
`else
        check("jz_taken_pc", 32'(output_address), 32'h02);
`endif
        input_zero_flag = 1'b0;
        to_execute(8'h7C);
        finish_instr;
`ifdef CONTROL_DECODER_BRANCH_EN
        check("jz_nottaken_pc", 32'(output_address), 32'h0D);
`else
        check("jz_nottaken_pc", 32'(output_address), 32'h03);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_decoder.md
Name: control_decoder

Overview:
- Sits directly downstream of the fetch/decode/execute/increment sequence generator and consumes its one-hot phase strobes.
- Owns the 8-bit program counter (PC) and instruction register (IR) of the 8-bit CPU.
- Decodes the 4-bit opcode into a registered control word and drives datapath strobes during the execute phase.
- Handles PC increment, jumps and halt.

Parameters:
ADDR_WIDTH, 8, PC / memory address width
DATA_WIDTH, 8, instruction and data byte width
OPCODE_WIDTH, 4, upper IR bits holding the opcode; the remaining DATA_WIDTH-OPCODE_WIDTH bits are the operand

Ports:
clock  input  1  system clock; all state updates on the rising edge
input_clear  input  1  synchronous, active-high reset
input_clock_enable  input  1  when 0, all state holds
input_fetch  input  1  fetch phase strobe
input_decode  input  1  decode phase strobe
input_execute  input  1  execute phase strobe
input_increment  input  1  increment phase strobe
input_instruction  input  8  instruction byte from program memory
input_zero_flag  input  1  ALU zero flag, sampled in execute
output_address  output  8  memory address: the PC in fetch/decode/increment; zero-extended operand in execute for memory opcodes
output_ir  output  8  current IR contents
output_operand  output  4  IR[3:0]
output_alu_op  output  2  00 pass, 01 add, 10 sub
output_acc_load  output  1  accumulator load strobe
output_mem_read  output  1  data memory read strobe
output_mem_write  output  1  data memory write strobe
output_imm_select  output  1  accumulator source is the operand, not memory
output_halt  output  1  CPU halted
output_illegal  output  1  one-cycle pulse: illegal opcode, or phase error

Behaviour:
- Reset (input_clear=1 at clock edge): PC=0x00, IR=0x00, control word=NOP, halt=0, jump_pending=0, output_illegal=0. All execute strobes are 0. input_clear overrides input_clock_enable and the phase strobes. Reset mid-instruction abandons that instruction with no partial writes.
- All updates are gated by input_clock_enable=1 and halt=0. The exception is input_clear.
- Phase error: more than one strobe high in the same cycle → no state change; output_illegal=1 for that cycle.
- Fetch: IR <= input_instruction at the edge. output_address=PC.
- Decode: registered control word <= decode(IR[7:4]), available from the next cycle. Illegal opcode → control word=NOP and output_illegal pulses for one cycle at this edge.
- Execute: datapath strobes are combinational (control word AND input_execute). They are high only while input_execute=1.
- Opcode table:
  - 0x0 NOP: no strobes.
  - 0x1 LDA: mem_read, acc_load, alu_op=00.
  - 0x2 ADD: mem_read, acc_load, alu_op=01.
  - 0x3 SUB: mem_read, acc_load, alu_op=10.
  - 0x4 STA: mem_write.
  - 0x5 LDI: acc_load, imm_select.
  - 0xF HLT: halt <= 1 at the execute edge.
  - Any other opcode: illegal.
- Memory opcodes (0x1-0x4) drive output_address={4'b0, operand} during execute.
- Increment: if jump_pending, PC <= {4'b0, operand} and jump_pending <= 0. Otherwise PC <= PC+1, wrapping 0xFF→0x00.
- Halt: output_halt=1. Strobes, PC and IR are frozen. Only input_clear leaves halt. HLT does not increment the PC, so the PC stays at the HLT address.
- output_ir and output_operand reflect IR at all times. output_alu_op is 00 outside execute.

Optional Feature:
- Macro: CONTROL_DECODER_BRANCH_EN
- Defined:
  - 0x6 JMP sets jump_pending=1 at the execute edge.
  - 0x7 JZ sets jump_pending=input_zero_flag at the execute edge.
  - Neither drives datapath strobes.
- Undefined: 0x6 and 0x7 decode as illegal (NOP plus output_illegal pulse). jump_pending is tied to 0.

Decomposition:
- Package cpu_isa_pkg holds:
  - opcode constants (OP_NOP … OP_HLT)
  - ALU op encodings (ALU_PASS, ALU_ADD, ALU_SUB)
  - packed control-word typedef {alu_op, acc_load, mem_read, mem_write, imm_select, halt, jump, jz, illegal}
  - NOP control-word constant
- Sub-module opcode_decode: purely combinational, maps the opcode to a control word. The parent holds PC, IR, control register, halt and jump state.

Test Plan:
- Reset then run: instruction 0x53 through fetch/decode/execute/increment → IR=0x53; during execute acc_load=1, imm_select=1, operand=3; PC=0x01 after increment.
- ADD 0x2A in execute → output_address=0x0A, mem_read=1, acc_load=1, alu_op=01. STA 0x47 → mem_write=1, address=0x07, acc_load=0.
- PC=0xFF, NOP cycle → PC wraps to 0x00. input_clock_enable=0 over a full phase set → PC and IR unchanged.
- HLT 0xF0 at PC=0x05 → output_halt=1, PC stays 0x05, later fetches are ignored. Assert input_clear → PC=0x00, halt=0.
- Opcode 0x9 → output_illegal pulses for one cycle at decode, no execute strobes. input_fetch and input_decode high together → output_illegal=1, IR unchanged.
- CONTROL_DECODER_BRANCH_EN defined:
  - JZ 0x7C with zero_flag=1 → PC=0x0C after increment.
  - With zero_flag=0 → PC+1.
  - JMP 0x63 → PC=0x03.
  - Macro undefined: JMP 0x63 → illegal pulse, PC+1.
